// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: ALUCtrl codes and FSM state encodings.
// The decoder uses the same ALU constants, so they are defined only here.
package fpu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_FPU_ADD = 4'b1110;
    localparam logic [3:0] ALU_FPU_MUL = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_WB    = 2'd2,
        S_DRAIN = 2'd3
    } fpu_state_e;

    function automatic logic is_fpu_ctrl(input logic [3:0] ctrl);
        return (ctrl == ALU_FPU_ADD) || (ctrl == ALU_FPU_MUL);
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_wdog.sv
// Watchdog counter bounding FPU latency: clears on request, counts while enabled,
// flags expiry at TIMEOUT-1 and saturates at TIMEOUT instead of wrapping.
module fpu_wdog_cnt #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Watchdog count register with clear priority and saturation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != CNT_SAT)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == CNT_EXP);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequences multi-cycle FPU add/mul ops from EX: latches operands, pulses start,
// stalls the pipeline until done or watchdog expiry, and drains results of aborted ops.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [REG_W-1:0]  rd_addr,
    input  logic              flush,
    output logic              fpu_start,
    output logic              fpu_op,
    output logic [DATA_W-1:0] fpu_a,
    output logic [DATA_W-1:0] fpu_b,
    input  logic              fpu_done,
    input  logic [DATA_W-1:0] fpu_result,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fpu_state_e        state_r;
    logic              timeout_r;
    logic              fpu_start_r;
    logic              fpu_op_r;
    logic [DATA_W-1:0] fpu_a_r;
    logic [DATA_W-1:0] fpu_b_r;
    logic              wb_valid_r;
    logic              wb_err_r;
    logic [REG_W-1:0]  wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;

    logic fpu_req_s;
    logic cnt_en_s;
    logic cnt_clr_s;
    logic expire_s;

    assign fpu_req_s = issue_valid && is_fpu_ctrl(alu_ctrl);
    assign cnt_en_s  = (state_r == S_BUSY) || (state_r == S_DRAIN);
    // Leaving BUSY always enters a new state, so the count restarts from zero there too
    assign cnt_clr_s = !cnt_en_s || ((state_r == S_BUSY) && (flush || fpu_done || expire_s));

    fpu_wdog_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .expire (expire_s)
    );

    // Issue FSM with operand latches and writeback registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            timeout_r   <= 1'b0;
            fpu_start_r <= 1'b0;
            fpu_op_r    <= 1'b0;
            fpu_a_r     <= '0;
            fpu_b_r     <= '0;
            wb_valid_r  <= 1'b0;
            wb_err_r    <= 1'b0;
            wb_rd_r     <= '0;
            wb_data_r   <= '0;
        end else begin
            fpu_start_r <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_err_r    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (fpu_req_s && !flush) begin
                        fpu_a_r     <= op_a;
                        fpu_b_r     <= op_b;
                        fpu_op_r    <= alu_ctrl[0];
                        wb_rd_r     <= rd_addr;
                        fpu_start_r <= 1'b1;
                        state_r     <= S_BUSY;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state_r <= fpu_done ? S_IDLE : S_DRAIN;
                    end else if (fpu_done) begin
                        wb_data_r  <= fpu_result;
                        wb_valid_r <= 1'b1;
                        timeout_r  <= 1'b0;
                        state_r    <= S_WB;
                    end else if (expire_s) begin
                        wb_data_r  <= '0;
                        wb_valid_r <= 1'b1;
                        wb_err_r   <= 1'b1;
                        timeout_r  <= 1'b1;
                        state_r    <= S_WB;
                    end else begin
                        state_r <= S_BUSY;
                    end
                end
                // A timed-out op still owes the FPU a late done, so it must be drained
                S_WB: begin
                    state_r <= timeout_r ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (fpu_done || expire_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign fpu_start = fpu_start_r;
    assign fpu_op    = fpu_op_r;
    assign fpu_a     = fpu_a_r;
    assign fpu_b     = fpu_b_r;
    assign wb_rd     = wb_rd_r;
    assign wb_data   = wb_data_r;
    // A flush in the WB cycle squashes the completing instruction
    assign wb_valid  = wb_valid_r && !flush;
    assign wb_err    = wb_err_r && !flush;
    assign stall     = (state_r == S_BUSY) ||
                       (fpu_req_s && ((state_r == S_IDLE) || (state_r == S_DRAIN)) && !flush);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: a transaction-level model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_fpu_issue_ctrl;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n, issue_valid, flush, fpu_done;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a, op_b, fpu_result;
    logic [4:0]  rd_addr;
    logic        fpu_start, fpu_op, stall, wb_valid, wb_err;
    logic [31:0] fpu_a, fpu_b, wb_data;
    logic [4:0]  wb_rd;

    int vec = 0;
    int errs = 0;

    fpu_issue_ctrl #(.DATA_W(32), .REG_W(5), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .alu_ctrl(alu_ctrl),
        .op_a(op_a), .op_b(op_b), .rd_addr(rd_addr), .flush(flush),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: op in flight with its age, a pending writeback, and a drain window with its age
    bit          m_active = 0, m_start = 0, m_wb = 0, m_wb_err = 0, m_drain_next = 0, m_drain = 0;
    int          m_age = 0, m_drain_age = 0;
    logic [31:0] m_a = '0, m_b = '0, m_wb_data = '0;
    logic [4:0]  m_rd = '0, m_wb_rd = '0;
    logic        m_op = 1'b0;

    // Observations for the hand-computed checks
    int          cyc = 0, stall_cnt = 0;
    int          start_cycs[$], wb_cycs[$];
    logic        start_ops[$], wb_errs[$];
    logic [4:0]  wb_rds[$];
    logic [31:0] wb_datas[$];

    always @(negedge clk) begin
        bit req, e_stall, e_wbv;
        req     = issue_valid && (alu_ctrl == 4'hE || alu_ctrl == 4'hF);
        e_stall = m_active || (req && !m_wb && !flush);
        e_wbv   = m_wb && !flush;
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("fpu_start", {31'd0, fpu_start}, {31'd0, m_start});
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
        chk("wb_err", {31'd0, wb_err}, {31'd0, e_wbv && m_wb_err});
        if (e_wbv) begin
            chk("wb_data", wb_data, m_wb_data);
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
        end
        if (m_active) begin
            chk("fpu_a", fpu_a, m_a);
            chk("fpu_b", fpu_b, m_b);
            chk("fpu_op", {31'd0, fpu_op}, {31'd0, m_op});
        end

        cyc++;
        if (stall) stall_cnt++;
        if (fpu_start) begin start_cycs.push_back(cyc); start_ops.push_back(fpu_op); end
        if (wb_valid) begin
            wb_cycs.push_back(cyc); wb_rds.push_back(wb_rd);
            wb_datas.push_back(wb_data); wb_errs.push_back(wb_err);
        end

        m_start = 0;
        if (!rst_n) begin
            m_active = 0; m_wb = 0; m_drain = 0; m_drain_next = 0;
        end else if (m_active) begin
            if (flush) begin
                m_active = 0; m_drain = !fpu_done; m_drain_age = 0;
            end else if (fpu_done) begin
                m_active = 0; m_wb = 1; m_wb_err = 0; m_wb_data = fpu_result;
                m_wb_rd = m_rd; m_drain_next = 0;
            end else if (m_age == TMO - 1) begin
                m_active = 0; m_wb = 1; m_wb_err = 1; m_wb_data = 0;
                m_wb_rd = m_rd; m_drain_next = 1;
            end else begin
                m_age++;
            end
        end else if (m_wb) begin
            m_wb = 0;
            if (m_drain_next) begin m_drain = 1; m_drain_age = 0; end
        end else if (m_drain) begin
            if (fpu_done || m_drain_age == TMO - 1) m_drain = 0;
            else m_drain_age++;
        end else if (req && !flush) begin
            m_active = 1; m_age = 0; m_start = 1;
            m_a = op_a; m_b = op_b; m_op = alu_ctrl[0]; m_rd = rd_addr;
        end
    end

    task automatic drv(input logic iv, input logic [3:0] ac, input logic [4:0] rd,
                       input logic fl, input logic dn, input logic [31:0] res);
        issue_valid = iv; alu_ctrl = ac; rd_addr = rd;
        flush = fl; fpu_done = dn; fpu_result = res;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon();
        stall_cnt = 0;
        start_cycs.delete(); wb_cycs.delete(); start_ops.delete();
        wb_errs.delete(); wb_rds.delete(); wb_datas.delete();
    endtask

    initial begin
        rst_n = 1'b0; op_a = '0; op_b = '0;
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        tick(2);
        rst_n = 1'b1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_start", {31'd0, fpu_start}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        tick(1);

        // Non-FPU ops, stray done and flushed FPU request in IDLE: nothing starts
        clear_mon();
        drv(1'b1, 4'b0010, 5'd1, 1'b0, 1'b1, 32'h55);  tick(1);
        drv(1'b1, 4'b1101, 5'd1, 1'b0, 1'b0, 32'h0);   tick(1);
        drv(1'b1, 4'hE, 5'd2, 1'b1, 1'b0, 32'h0);      tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(1);
        chk("idle_starts", start_cycs.size(), 32'd0);
        chk("idle_stalls", stall_cnt, 32'd0);

        // 1: add, done three cycles after start
        clear_mon();
        op_a = 32'h3F800000; op_b = 32'h40000000;
        drv(1'b1, 4'hE, 5'd3, 1'b0, 1'b0, 32'h0);        tick(4);
        drv(1'b1, 4'hE, 5'd3, 1'b0, 1'b1, 32'h40400000); tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);        tick(2);
        chk("t1_stall_cycles", stall_cnt, 32'd5);
        chk("t1_starts", start_cycs.size(), 32'd1);
        chk("t1_wbs", wb_cycs.size(), 32'd1);
        if (wb_cycs.size() == 1) begin
            chk("t1_wb_data", wb_datas[0], 32'h40400000);
            chk("t1_wb_err", {31'd0, wb_errs[0]}, 32'd0);
            chk("t1_latency", wb_cycs[0] - start_cycs[0], 32'd4);
        end

        // 2: mul times out; a queued add waits in DRAIN until the late done
        clear_mon();
        op_a = 32'h1; op_b = 32'h2;
        drv(1'b1, 4'hF, 5'd7, 1'b0, 1'b0, 32'h0);      tick(16);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(1);
        drv(1'b1, 4'hE, 5'd9, 1'b0, 1'b0, 32'h0);      tick(3);
        drv(1'b1, 4'hE, 5'd9, 1'b0, 1'b1, 32'hDEAD);   tick(1);
        drv(1'b1, 4'hE, 5'd9, 1'b0, 1'b0, 32'h0);      tick(2);
        drv(1'b1, 4'hE, 5'd9, 1'b0, 1'b1, 32'h12345678); tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(2);
        chk("t2_stall_cycles", stall_cnt, 32'd23);
        chk("t2_wbs", wb_cycs.size(), 32'd2);
        if (wb_cycs.size() == 2 && start_cycs.size() == 2) begin
            chk("t2_timeout_latency", wb_cycs[0] - start_cycs[0], 32'd15);
            chk("t2_err", {31'd0, wb_errs[0]}, 32'd1);
            chk("t2_err_data", wb_datas[0], 32'd0);
            chk("t2_err_rd", {27'd0, wb_rds[0]}, 32'd7);
            chk("t2_restart_gap", start_cycs[1] - start_cycs[0], 32'd21);
            chk("t2_second_data", wb_datas[1], 32'h12345678);
        end

        // 2b: timeout with no late done; DRAIN expires after 15 cycles
        clear_mon();
        drv(1'b1, 4'hF, 5'd4, 1'b0, 1'b0, 32'h0);      tick(16);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(1);
        drv(1'b1, 4'hE, 5'd5, 1'b0, 1'b0, 32'h0);      tick(17);
        drv(1'b1, 4'hE, 5'd5, 1'b0, 1'b1, 32'h42);     tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(2);
        chk("t2b_wbs", wb_cycs.size(), 32'd2);
        if (wb_cycs.size() >= 1 && start_cycs.size() == 2)
            chk("t2b_drain_gap", start_cycs[1] - wb_cycs[0], 32'd17);

        // 3: flush two cycles after start, late done discarded
        clear_mon();
        drv(1'b1, 4'hE, 5'd12, 1'b0, 1'b0, 32'h0);     tick(3);
        drv(1'b0, 4'h0, 5'd0, 1'b1, 1'b0, 32'h0);      tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b1, 32'hBAD);    tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(2);
        chk("t3_wbs", wb_cycs.size(), 32'd0);
        chk("t3_starts", start_cycs.size(), 32'd1);

        // 4: flush with done in BUSY goes straight to IDLE and accepts at once
        clear_mon();
        drv(1'b1, 4'hF, 5'd13, 1'b0, 1'b0, 32'h0);     tick(3);
        drv(1'b1, 4'hF, 5'd13, 1'b1, 1'b1, 32'h77);    tick(1);
        drv(1'b1, 4'hE, 5'd14, 1'b0, 1'b0, 32'h0);     tick(2);
        drv(1'b1, 4'hE, 5'd14, 1'b0, 1'b1, 32'h88);    tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(2);
        chk("t4_starts", start_cycs.size(), 32'd2);
        chk("t4_wbs", wb_cycs.size(), 32'd1);
        if (wb_cycs.size() == 1) chk("t4_wb_rd", {27'd0, wb_rds[0]}, 32'd14);

        // 5: back-to-back add then mul
        clear_mon();
        drv(1'b1, 4'hE, 5'd10, 1'b0, 1'b0, 32'h0);     tick(2);
        drv(1'b1, 4'hE, 5'd10, 1'b0, 1'b1, 32'h11);    tick(1);
        drv(1'b1, 4'hE, 5'd10, 1'b0, 1'b0, 32'h0);     tick(1);
        drv(1'b1, 4'hF, 5'd11, 1'b0, 1'b0, 32'h0);     tick(2);
        drv(1'b1, 4'hF, 5'd11, 1'b0, 1'b1, 32'h22);    tick(1);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(2);
        chk("t5_wbs", wb_cycs.size(), 32'd2);
        if (wb_cycs.size() == 2 && start_cycs.size() == 2) begin
            chk("t5_accept_after_wb", start_cycs[1] - wb_cycs[0], 32'd2);
            chk("t5_op0", {31'd0, start_ops[0]}, 32'd0);
            chk("t5_op1", {31'd0, start_ops[1]}, 32'd1);
            chk("t5_rd0", {27'd0, wb_rds[0]}, 32'd10);
            chk("t5_rd1", {27'd0, wb_rds[1]}, 32'd11);
            chk("t5_data1", wb_datas[1], 32'h22);
        end

        // 6: reset while BUSY, then a stray done
        clear_mon();
        op_a = 32'hA5A5A5A5; op_b = 32'h5A5A5A5A;
        drv(1'b1, 4'hF, 5'd15, 1'b0, 1'b0, 32'h0);     tick(2);
        rst_n = 1'b0;                                  tick(1);
        rst_n = 1'b1;
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b1, 32'h99);     tick(1);
        chk("t6_fpu_a", fpu_a, 32'd0);
        chk("t6_fpu_op", {31'd0, fpu_op}, 32'd0);
        chk("t6_wb_data", wb_data, 32'd0);
        chk("t6_stall", {31'd0, stall}, 32'd0);
        drv(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0);      tick(2);
        chk("t6_wbs", wb_cycs.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
